// File: rtl/hwpe_tcdm_wide_splitter.sv
// hwpe_tcdm_wide_splitter
// Splits one wide HWPE TCDM access into NrPorts narrow TCDM accesses, one per
// consecutive narrow word, and merges the narrow responses back into one wide
// response. Ports are granted independently and only one wide transaction is
// outstanding at a time.
//
// Narrow request/response records are carried as packed vectors, one slice per
// port (port k occupies [k*Width +: Width]). Field layout, MSB first:
//   request  : q_valid | addr[AddrWidth] | write | strb[NarrowBytes]
//              | data[NarrowDataWidth] | amo[4] | user[UserWidth]
//   response : q_ready | p_valid | p_data[NarrowDataWidth]
module hwpe_tcdm_wide_splitter #(
  parameter int unsigned WideDataWidth   = 256,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned UserWidth       = 1,
  localparam int unsigned NrPorts     = WideDataWidth / NarrowDataWidth,
  localparam int unsigned NarrowBytes = NarrowDataWidth / 8,
  localparam int unsigned ReqWidth    = 1 + AddrWidth + 1 + NarrowBytes + NarrowDataWidth + 4 + UserWidth,
  localparam int unsigned RspWidth    = 2 + NarrowDataWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  output logic                          gnt_o,
  input  logic [AddrWidth-1:0]          add_i,
  input  logic                          wen_i,
  input  logic [WideDataWidth/8-1:0]    be_i,
  input  logic [WideDataWidth-1:0]      data_i,
  output logic                          r_valid_o,
  output logic [WideDataWidth-1:0]      r_data_o,
  output logic [NrPorts*ReqWidth-1:0]   tcdm_req_o,
  input  logic [NrPorts*RspWidth-1:0]   tcdm_rsp_i
);

  localparam int unsigned WideOffBits = $clog2(WideDataWidth / 8);
  localparam int unsigned QReadyBit   = NarrowDataWidth + 1;
  localparam int unsigned PValidBit   = NarrowDataWidth;
  localparam logic [3:0]  AmoNone     = 4'h0;

  if ((WideDataWidth % NarrowDataWidth) != 0) begin : g_bad_width
    $error("WideDataWidth must be a multiple of NarrowDataWidth");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e               state_q, state_d;
  logic [NrPorts-1:0]   gnt_mask_q, gnt_mask_d;
  logic [NrPorts-1:0]   rsp_mask_q, rsp_mask_d;
  logic [NrPorts-1:0]   skip_q, skip_d;
  logic [NrPorts-1:0]   skip, q_valid, q_ready, p_valid, hs;
  logic                 issue_en;
  logic [AddrWidth-1:0] wide_base;

  // Sub-word offset bits select nothing: the wide access is always word aligned.
  logic unused_offset;
  assign unused_offset = ^add_i[WideOffBits-1:0];
  assign wide_base     = {add_i[AddrWidth-1:WideOffBits], {WideOffBits{1'b0}}};

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_port
    localparam logic [AddrWidth-1:0] PortOff = AddrWidth'(gi * NarrowBytes);

    logic [NarrowDataWidth-1:0] p_data;
    logic [NarrowDataWidth-1:0] rdata_q;

    // A write with no enabled byte in this slice needs no narrow access at all.
    assign skip[gi]    = ~wen_i & ~(|be_i[gi*NarrowBytes +: NarrowBytes]);
    assign q_ready[gi] = tcdm_rsp_i[gi*RspWidth + QReadyBit];
    assign p_valid[gi] = tcdm_rsp_i[gi*RspWidth + PValidBit];
    assign p_data      = tcdm_rsp_i[gi*RspWidth +: NarrowDataWidth];

    assign tcdm_req_o[gi*ReqWidth +: ReqWidth] = {
      q_valid[gi],
      wide_base + PortOff,
      ~wen_i,
      be_i[gi*NarrowBytes +: NarrowBytes],
      data_i[gi*NarrowDataWidth +: NarrowDataWidth],
      AmoNone,
      {UserWidth{1'b0}}
    };

    // Hold early narrow responses until the slowest port has answered.
    always_ff @(posedge clk_i) begin
      if (p_valid[gi]) rdata_q <= p_data;
    end

    assign r_data_o[gi*NarrowDataWidth +: NarrowDataWidth] = p_valid[gi] ? p_data : rdata_q;
  end

  // State and bookkeeping masks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_mask_q <= '0;
      rsp_mask_q <= '0;
      skip_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_mask_q <= gnt_mask_d;
      rsp_mask_q <= rsp_mask_d;
      skip_q     <= skip_d;
    end
  end

  // Next state and mask updates.
  always_comb begin
    state_d    = state_q;
    gnt_mask_d = gnt_o ? '0 : (gnt_mask_q | hs);
    rsp_mask_d = r_valid_o ? '0 : (rsp_mask_q | p_valid);
    skip_d     = gnt_o ? skip : skip_q;
    case (state_q)
      IDLE: begin
        if (gnt_o)      state_d = WAIT_RSP;
        else if (|hs)   state_d = ISSUE;
      end
      ISSUE: begin
        if (gnt_o)      state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (r_valid_o)  state_d = IDLE;
      end
      default:          state_d = IDLE;
    endcase
  end

  // Narrow request valids, wide grant and wide response valid.
  always_comb begin
    issue_en  = req_i & (state_q != WAIT_RSP);
    q_valid   = issue_en ? (~gnt_mask_q & ~skip) : '0;
    hs        = q_valid & q_ready;
    gnt_o     = issue_en & (&(gnt_mask_q | skip | hs));
    r_valid_o = (state_q == WAIT_RSP) & (&(rsp_mask_q | skip_q | p_valid));
  end

`ifndef SYNTHESIS
  logic [NrPorts-1:0] outstanding;
  assign outstanding = ~rsp_mask_q &
      (({NrPorts{state_q == ISSUE}} & gnt_mask_q) |
       ({NrPorts{state_q == WAIT_RSP}} & ~skip_q));

  a_no_stray_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (p_valid & ~outstanding) == '0);

  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != ISSUE) || req_i);
`endif

endmodule

// File: tb/tb_hwpe_tcdm_wide_splitter.sv
// Directed bench for hwpe_tcdm_wide_splitter (4 x 64-bit narrow ports).
module tb_hwpe_tcdm_wide_splitter;

  localparam int W    = 256;
  localparam int NW   = 64;
  localparam int AW   = 32;
  localparam int UW   = 1;
  localparam int NP   = 4;
  localparam int NB   = 8;
  localparam int REQW = 1 + AW + 1 + NB + NW + 4 + UW;
  localparam int RSPW = 2 + NW;
  localparam int AMO_LSB   = UW;
  localparam int DATA_LSB  = UW + 4;
  localparam int STRB_LSB  = DATA_LSB + NW;
  localparam int WRITE_BIT = STRB_LSB + NB;
  localparam int ADDR_LSB  = WRITE_BIT + 1;
  localparam int VALID_BIT = ADDR_LSB + AW;

  logic            clk_i, rst_ni, req_i, gnt_o, wen_i, r_valid_o;
  logic [AW-1:0]   add_i;
  logic [W/8-1:0]  be_i;
  logic [W-1:0]    data_i, r_data_o;
  logic [NP*REQW-1:0] tcdm_req_o;
  logic [NP*RSPW-1:0] tcdm_rsp_i;

  logic [NP-1:0]   qv, wr, q_ready, p_valid;
  logic [AW-1:0]   addr [NP];
  logic [NB-1:0]   strb [NP];
  logic [NW-1:0]   wdat [NP];
  logic [3:0]      amo  [NP];
  logic [NW-1:0]   p_data [NP];
  logic [NP-1:0]   qv_acc;

  int n_cmp = 0;
  int n_err = 0;

  hwpe_tcdm_wide_splitter #(
    .WideDataWidth(W), .NarrowDataWidth(NW), .AddrWidth(AW), .UserWidth(UW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_rsp_i(tcdm_rsp_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always_comb begin
    qv = '0;
    wr = '0;
    for (int k = 0; k < NP; k++) begin
      qv[k]   = tcdm_req_o[k*REQW + VALID_BIT];
      wr[k]   = tcdm_req_o[k*REQW + WRITE_BIT];
      addr[k] = tcdm_req_o[k*REQW + ADDR_LSB +: AW];
      strb[k] = tcdm_req_o[k*REQW + STRB_LSB +: NB];
      wdat[k] = tcdm_req_o[k*REQW + DATA_LSB +: NW];
      amo[k]  = tcdm_req_o[k*REQW + AMO_LSB +: 4];
    end
  end

  always_comb begin
    tcdm_rsp_i = '0;
    for (int k = 0; k < NP; k++)
      tcdm_rsp_i[k*RSPW +: RSPW] = {q_ready[k], p_valid[k], p_data[k]};
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
    qv_acc = qv_acc | qv;
  endtask

  task automatic idle_in();
    req_i = 1'b0; q_ready = '0; p_valid = '0;
    for (int k = 0; k < NP; k++) p_data[k] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; add_i = '0; wen_i = 1'b1; be_i = '0; data_i = '0; qv_acc = '0;
    idle_in();
    #2;
    chk("rst_gnt", 256'(gnt_o), 256'(1'b0));
    chk("rst_rvalid", 256'(r_valid_o), 256'(1'b0));
    chk("rst_qvalid", 256'(qv), 256'(4'h0));
    nxt(); nxt();
    rst_ni = 1'b1;

    // T1: read 0x1000, all ports ready at once
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1000; be_i = '1; q_ready = 4'hF;
    smp();
    chk("t1_gnt_c0", 256'(gnt_o), 256'(1'b1));
    chk("t1_qv_c0", 256'(qv), 256'(4'hF));
    chk("t1_addr0", 256'(addr[0]), 256'(32'h1000));
    chk("t1_addr1", 256'(addr[1]), 256'(32'h1008));
    chk("t1_addr2", 256'(addr[2]), 256'(32'h1010));
    chk("t1_addr3", 256'(addr[3]), 256'(32'h1018));
    chk("t1_write", 256'(wr), 256'(4'h0));
    chk("t1_amo2", 256'(amo[2]), 256'(4'h0));
    chk("t1_rvalid_c0", 256'(r_valid_o), 256'(1'b0));
    nxt();
    idle_in(); p_valid = 4'hF;
    for (int k = 0; k < NP; k++) p_data[k] = 64'(k) * 64'h1111;
    smp();
    chk("t1_qv_c1", 256'(qv), 256'(4'h0));
    chk("t1_rvalid_c1", 256'(r_valid_o), 256'(1'b1));
    chk("t1_rdata", r_data_o, {64'h3333, 64'h2222, 64'h1111, 64'h0});
    nxt();
    idle_in();
    smp();
    chk("t1_rvalid_c2", 256'(r_valid_o), 256'(1'b0));

    // T2: read with staggered grants, offset address bits ignored
    nxt();
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h2013; q_ready = 4'b0011;
    smp();
    chk("t2_qv_c0", 256'(qv), 256'(4'hF));
    chk("t2_gnt_c0", 256'(gnt_o), 256'(1'b0));
    chk("t2_addr0", 256'(addr[0]), 256'(32'h2000));
    nxt();
    q_ready = 4'b0000; p_valid = 4'b0011;
    p_data[0] = 64'hA0A0_0000_0000_00A0; p_data[1] = 64'hA1A1_0000_0000_00A1;
    smp();
    chk("t2_qv_c1", 256'(qv), 256'(4'b1100));
    chk("t2_gnt_c1", 256'(gnt_o), 256'(1'b0));
    nxt();
    q_ready = 4'b0100; p_valid = 4'b0000; p_data[0] = '0; p_data[1] = '0;
    smp();
    chk("t2_qv_c2", 256'(qv), 256'(4'b1100));
    chk("t2_gnt_c2", 256'(gnt_o), 256'(1'b0));
    nxt();
    q_ready = 4'b0000; p_valid = 4'b0100; p_data[2] = 64'hA2A2_0000_0000_00A2;
    smp();
    chk("t2_qv_c3", 256'(qv), 256'(4'b1000));
    nxt();
    q_ready = 4'b1000; p_valid = 4'b0000; p_data[2] = '0;
    smp();
    chk("t2_gnt_c4", 256'(gnt_o), 256'(1'b1));
    chk("t2_addr3", 256'(addr[3]), 256'(32'h2018));
    nxt();
    idle_in(); p_valid = 4'b1000; p_data[3] = 64'hA3A3_0000_0000_00A3;
    smp();
    chk("t2_rvalid_c5", 256'(r_valid_o), 256'(1'b1));
    chk("t2_rdata", r_data_o, {64'hA3A3_0000_0000_00A3, 64'hA2A2_0000_0000_00A2,
                               64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0});
    nxt();
    idle_in();

    // T3: sparse write, only ports 1 and 2 carry enabled bytes
    qv_acc = '0;
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h3000; be_i = 32'h00FF_FF00;
    data_i = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    q_ready = 4'b0010;
    smp();
    chk("t3_qv_c0", 256'(qv), 256'(4'b0110));
    chk("t3_strb1", 256'(strb[1]), 256'(8'hFF));
    chk("t3_wdat1", 256'(wdat[1]), 256'(64'h2222_2222_2222_2222));
    chk("t3_write", 256'(wr), 256'(4'hF));
    chk("t3_gnt_c0", 256'(gnt_o), 256'(1'b0));
    nxt();
    q_ready = 4'b0100; p_valid = 4'b0010;
    smp();
    chk("t3_qv_c1", 256'(qv), 256'(4'b0100));
    chk("t3_gnt_c1", 256'(gnt_o), 256'(1'b1));
    nxt();
    idle_in(); p_valid = 4'b0100;
    smp();
    chk("t3_rvalid_c2", 256'(r_valid_o), 256'(1'b1));
    chk("t3_skipped_qv", 256'(qv_acc & 4'b1001), 256'(4'b0000));
    nxt();
    idle_in();

    // T4: write with no enabled bytes completes without narrow traffic
    qv_acc = '0;
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h3100; be_i = '0;
    smp();
    chk("t4_gnt_c0", 256'(gnt_o), 256'(1'b1));
    chk("t4_rvalid_c0", 256'(r_valid_o), 256'(1'b0));
    nxt();
    idle_in();
    smp();
    chk("t4_rvalid_c1", 256'(r_valid_o), 256'(1'b1));
    chk("t4_no_qv", 256'(qv_acc), 256'(4'h0));
    nxt();

    // T5: back-to-back reads, request held across the first response
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h4000; be_i = '1; q_ready = 4'hF;
    smp();
    chk("t5_gnt_a", 256'(gnt_o), 256'(1'b1));
    nxt();
    add_i = 32'h5000; p_valid = 4'hF;
    for (int k = 0; k < NP; k++) p_data[k] = 64'h5500 + 64'(k);
    smp();
    chk("t5_rvalid_a", 256'(r_valid_o), 256'(1'b1));
    chk("t5_gnt_wait", 256'(gnt_o), 256'(1'b0));
    chk("t5_qv_wait", 256'(qv), 256'(4'h0));
    nxt();
    p_valid = 4'h0;
    smp();
    chk("t5_gnt_b", 256'(gnt_o), 256'(1'b1));
    chk("t5_addr_b", 256'(addr[0]), 256'(32'h5000));
    nxt();
    idle_in(); p_valid = 4'hF;
    for (int k = 0; k < NP; k++) p_data[k] = 64'h6600 + 64'(k);
    smp();
    chk("t5_rvalid_b", 256'(r_valid_o), 256'(1'b1));
    chk("t5_rdata_b", r_data_o, {64'h6603, 64'h6602, 64'h6601, 64'h6600});
    nxt();
    idle_in();

    // T6: reset while two of four ports are granted
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h6000; q_ready = 4'b0101;
    smp();
    chk("t6_gnt_c0", 256'(gnt_o), 256'(1'b0));
    nxt();
    q_ready = 4'b0000;
    smp();
    chk("t6_qv_c1", 256'(qv), 256'(4'b1010));
    #1;
    rst_ni = 1'b0; req_i = 1'b0;
    #1;
    chk("t6_rst_gnt", 256'(gnt_o), 256'(1'b0));
    chk("t6_rst_rvalid", 256'(r_valid_o), 256'(1'b0));
    chk("t6_rst_qv", 256'(qv), 256'(4'h0));
    nxt(); nxt();
    rst_ni = 1'b1;
    req_i = 1'b1; add_i = 32'h7000; q_ready = 4'hF;
    smp();
    chk("t6_reissue_qv", 256'(qv), 256'(4'hF));
    chk("t6_reissue_gnt", 256'(gnt_o), 256'(1'b1));
    nxt();
    idle_in(); p_valid = 4'hF;
    for (int k = 0; k < NP; k++) p_data[k] = 64'h7700 + 64'(k);
    smp();
    chk("t6_rvalid", 256'(r_valid_o), 256'(1'b1));
    chk("t6_rdata", r_data_o, {64'h7703, 64'h7702, 64'h7701, 64'h7700});
    nxt();
    idle_in();
    smp();
    chk("t6_rvalid_end", 256'(r_valid_o), 256'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
